// File: rtl/bcd_seven_seg_scanner.sv
// bcd_seven_seg_scanner
//   Drives a 4-digit, time-multiplexed, common-anode seven-segment display
//   from a 16-bit unpacked BCD word. A load strobe captures the word into a
//   pending register. The display copy takes that word only at a frame
//   boundary (the tick that enters DIG0), so a frame is never torn.
//
// Parameters
//   SCAN_DIV     clock cycles per digit slot (1..65535)
//
// Optional build macro
//   LEADING_ZERO_BLANK_EN  blanks leading zero digits 3..1 (digit0 always lit)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   unpacked_bcd  four BCD nibbles, digit3=[15:12] .. digit0=[3:0]
//   bcd_load      one-cycle strobe, captures unpacked_bcd
//   an            digit enables, active-low one-hot (an[k] selects digit k)
//   seg           segments {g,f,e,d,c,b,a}, active-high
//   frame_done    one-cycle pulse coincident with the first DIG0 cycle
//   pending       captured data waiting for a frame boundary
module bcd_seven_seg_scanner #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] unpacked_bcd,
    input  logic        bcd_load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done,
    output logic        pending
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DIG0 = 3'd1,
        S_DIG1 = 3'd2,
        S_DIG2 = 3'd3,
        S_DIG3 = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             boundary;
    logic [15:0]      display, disp_nxt;
    logic [15:0]      pend_reg;
    logic [1:0]       dig_sel;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       dig_val;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79; // non-BCD nibble shows 'E'
        endcase
        return s;
    endfunction

    // Prescaler: tick in the cycle where the count sits at SCAN_DIV-1.
    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_OFF;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                S_OFF:   state_nxt = S_DIG0;
                S_DIG0:  state_nxt = S_DIG1;
                S_DIG1:  state_nxt = S_DIG2;
                S_DIG2:  state_nxt = S_DIG3;
                S_DIG3:  state_nxt = S_DIG0;
                default: state_nxt = S_OFF;
            endcase
        end
    end

    assign boundary = tick && (state == S_OFF || state == S_DIG3);

    // FSM outputs: next-cycle values for the registered display outputs.
    // The digit being entered is decoded from disp_nxt so that a frame
    // boundary (including a same-cycle load bypass) shows new data at once.
    always_comb begin
        disp_nxt = display;
        if (boundary) begin
            if (bcd_load)     disp_nxt = unpacked_bcd;
            else if (pending) disp_nxt = pend_reg;
        end

        case (state_nxt)
            S_DIG1:  dig_sel = 2'd1;
            S_DIG2:  dig_sel = 2'd2;
            S_DIG3:  dig_sel = 2'd3;
            default: dig_sel = 2'd0;
        endcase
        dig_val = disp_nxt[{dig_sel, 2'b00} +: 4];

        an_nxt  = an;
        seg_nxt = seg;
        if (tick) begin
            an_nxt  = ~(4'b0001 << dig_sel);
`ifdef LEADING_ZERO_BLANK_EN
            // A digit is blank when it and every higher digit are zero.
            case (dig_sel)
                2'd3:    seg_nxt = (disp_nxt[15:12] == 4'd0) ? 7'h00 : decode(dig_val);
                2'd2:    seg_nxt = (disp_nxt[15:8]  == 8'd0) ? 7'h00 : decode(dig_val);
                2'd1:    seg_nxt = (disp_nxt[15:4]  == 12'd0) ? 7'h00 : decode(dig_val);
                default: seg_nxt = decode(dig_val);
            endcase
`else
            seg_nxt = decode(dig_val);
`endif
        end
    end

    // Registered outputs and display data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg        <= 7'h00;
            frame_done <= 1'b0;
            display    <= 16'h0000;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
            display    <= disp_nxt;
        end
    end

    // Pending capture; last write before the boundary wins. A load that
    // coincides with the boundary bypasses to display, so pending clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= 16'h0000;
            pending  <= 1'b0;
        end else begin
            if (bcd_load) pend_reg <= unpacked_bcd;
            if (boundary)      pending <= 1'b0;
            else if (bcd_load) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// Directed testbench for bcd_seven_seg_scanner with SCAN_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] unpacked_bcd = 16'h0000;
    logic        bcd_load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        pending;

    int n_cmp = 0;
    int n_err = 0;

    bcd_seven_seg_scanner #(.SCAN_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .unpacked_bcd (unpacked_bcd),
        .bcd_load     (bcd_load),
        .an           (an),
        .seg          (seg),
        .frame_done   (frame_done),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an !== 4'b1111 || seg !== 7'h00 || frame_done !== 1'b0 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: an=%b seg=%h fd=%b pend=%b required an=1111 seg=00 fd=0 pend=0",
                     an, seg, frame_done, pending);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (an !== 4'b1111 || seg !== 7'h00 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL off_cycle%0d: an=%b seg=%h fd=%b required an=1111 seg=00 fd=0",
                         i, an, seg, frame_done);
            end
            step();
        end
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'h3F || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL first_digit: an=%b seg=%h fd=%b required an=1110 seg=3F fd=1",
                     an, seg, frame_done);
        end
        step();
        n_cmp++;
        if (frame_done !== 1'b0 || an !== 4'b1110) begin
            n_err++;
            $display("FAIL fd_pulse_width: fd=%b an=%b required fd=0 an=1110", frame_done, an);
        end
    endtask

    // Load 0255 during OFF; check the first frame slot by slot.
    task automatic test_load_off();
        logic [6:0] exp_seg [4];
        int n;
        exp_seg[0] = 7'h6D;
        exp_seg[1] = 7'h6D;
        exp_seg[2] = 7'h5B;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg[3] = 7'h00;
`else
        exp_seg[3] = 7'h3F;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        unpacked_bcd = 16'h0255;
        bcd_load = 1'b1;
        step();
        bcd_load = 1'b0;
        n_cmp++;
        if (pending !== 1'b1) begin
            n_err++;
            $display("FAIL load_off_pending: pending=%b required 1", pending);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL load_off_boundary: fd=%b pending=%b required fd=1 pending=0",
                     frame_done, pending);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (an !== ~(4'b0001 << k) || seg !== exp_seg[k] ||
                    frame_done !== (k == 0 && c == 0)) begin
                    n_err++;
                    $display("FAIL load_off_d%0d_c%0d: an=%b seg=%h fd=%b required an=%b seg=%h fd=%b",
                             k, c, an, seg, frame_done, ~(4'b0001 << k), exp_seg[k],
                             (k == 0 && c == 0));
                end
                step();
            end
        end
    endtask

    // Entered at a frame start showing 0255.
    task automatic test_last_write_wins();
        logic [6:0] old_seg [4];
        logic [6:0] new_seg [4];
        old_seg[0] = 7'h6D;
        old_seg[1] = 7'h6D;
        old_seg[2] = 7'h5B;
        new_seg[0] = 7'h6F;
        new_seg[1] = 7'h6F;
`ifdef LEADING_ZERO_BLANK_EN
        old_seg[3] = 7'h00;
        new_seg[2] = 7'h00;
        new_seg[3] = 7'h00;
`else
        old_seg[3] = 7'h3F;
        new_seg[2] = 7'h3F;
        new_seg[3] = 7'h3F;
`endif
        unpacked_bcd = 16'h0128;
        bcd_load = 1'b1;
        step();
        unpacked_bcd = 16'h0099;
        step();
        bcd_load = 1'b0;
        n_cmp++;
        if (pending !== 1'b1) begin
            n_err++;
            $display("FAIL lww_pending: pending=%b required 1", pending);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k == 0 && c < 2) continue;
                n_cmp++;
                if (seg !== old_seg[k]) begin
                    n_err++;
                    $display("FAIL lww_midframe_d%0d_c%0d: seg=%h required %h", k, c, seg, old_seg[k]);
                end
                step();
            end
        end
        n_cmp++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL lww_boundary: fd=%b pending=%b required fd=1 pending=0", frame_done, pending);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (an !== ~(4'b0001 << k) || seg !== new_seg[k]) begin
                n_err++;
                $display("FAIL lww_new_d%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, ~(4'b0001 << k), new_seg[k]);
            end
            repeat (4) step();
        end
    endtask

    // Entered at a frame start; load lands on the DIG3->DIG0 tick.
    task automatic test_bypass();
        repeat (15) step();
        n_cmp++;
        if (an !== 4'b0111) begin
            n_err++;
            $display("FAIL bypass_align: an=%b required 0111", an);
        end
        unpacked_bcd = 16'h0007;
        bcd_load = 1'b1;
        step();
        bcd_load = 1'b0;
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'h07 || frame_done !== 1'b1 || pending !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_dig0: an=%b seg=%h fd=%b pending=%b required an=1110 seg=07 fd=1 pending=0",
                     an, seg, frame_done, pending);
        end
        repeat (4) step();
        n_cmp++;
`ifdef LEADING_ZERO_BLANK_EN
        if (an !== 4'b1101 || seg !== 7'h00) begin
            n_err++;
            $display("FAIL bypass_dig1: an=%b seg=%h required an=1101 seg=00", an, seg);
        end
`else
        if (an !== 4'b1101 || seg !== 7'h3F) begin
            n_err++;
            $display("FAIL bypass_dig1: an=%b seg=%h required an=1101 seg=3F", an, seg);
        end
`endif
        repeat (12) step();
    endtask

    // Entered at a frame start; non-BCD nibbles decode to 'E'.
    task automatic test_invalid_digits();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h4F;
        exp_seg[1] = 7'h79;
        exp_seg[2] = 7'h3F;
        exp_seg[3] = 7'h79;
        unpacked_bcd = 16'hA0F3;
        bcd_load = 1'b1;
        step();
        bcd_load = 1'b0;
        repeat (15) step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (an !== ~(4'b0001 << k) || seg !== exp_seg[k]) begin
                n_err++;
                $display("FAIL invalid_d%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, ~(4'b0001 << k), exp_seg[k]);
            end
            repeat (4) step();
        end
    endtask

    // Entered at a frame start; asynchronous reset while DIG2 with pending.
    task automatic test_reset_mid_frame();
        logic [6:0] exp_seg [4];
        int n;
        exp_seg[0] = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg[1] = 7'h00;
        exp_seg[2] = 7'h00;
        exp_seg[3] = 7'h00;
`else
        exp_seg[1] = 7'h3F;
        exp_seg[2] = 7'h3F;
        exp_seg[3] = 7'h3F;
`endif
        unpacked_bcd = 16'h0255;
        bcd_load = 1'b1;
        step();
        bcd_load = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (an !== 4'b1011 || pending !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_setup: an=%b pending=%b required an=1011 pending=1", an, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (an !== 4'b1111 || seg !== 7'h00 || pending !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: an=%b seg=%h pending=%b fd=%b required an=1111 seg=00 pending=0 fd=0",
                     an, seg, pending, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL rstmid_latency: cycles=%0d required 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (an !== ~(4'b0001 << k) || seg !== exp_seg[k]) begin
                n_err++;
                $display("FAIL rstmid_d%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, ~(4'b0001 << k), exp_seg[k]);
            end
            repeat (4) step();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_off();
        test_last_write_wins();
        test_bypass();
        test_invalid_digits();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_seven_seg_scanner.md
Name: bcd_seven_seg_scanner

Overview:
- Downstream consumer of the binary-to-BCD converter's unpacked_bcd output.
- Drives a 4-digit, time-multiplexed, common-anode seven-segment display.
- Captures a BCD word on a load strobe and holds it in a pending register. The display copy updates only at a frame boundary, so the display never tears.
- Scan rate is set by a programmable prescaler.

Parameters:
- SCAN_DIV, 4: clock cycles per digit slot. Legal range 1..65535; 1 means a tick every cycle. The prescaler counter width is $clog2(SCAN_DIV) with a minimum of 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- unpacked_bcd  input  16  four BCD nibbles. Digit3 = [15:12], digit2 = [11:8], digit1 = [7:4], digit0 = [3:0].
- bcd_load  input  1  one-cycle strobe; captures unpacked_bcd.
- an  output  4  digit enables, active-low one-hot; an[k] selects digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- frame_done  output  1  one-cycle pulse at the start of each frame.
- pending  output  1  high while captured data is waiting for a frame boundary.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst_n=0) sets: an=4'b1111, seg=7'h00, frame_done=0, pending=0, prescaler=0, display=16'h0000, pending register=16'h0000, FSM=OFF.
- Prescaler: counts 0..SCAN_DIV-1. A tick occurs in the cycle where count==SCAN_DIV-1; the count then wraps to 0.
- FSM states: OFF, DIG0, DIG1, DIG2, DIG3.
  - OFF -> DIG0 on the first tick.
  - DIGn -> DIG(n+1) on a tick; DIG3 -> DIG0 on a tick.
  - No transition without a tick.
- Frame boundary: any tick whose transition enters DIG0 (from OFF or from DIG3).
- On entering DIGk, the same clock edge loads:
  - an = ~(4'b0001 << k)
  - seg = decode(display digit k), using the display value already updated at this edge if it is a frame boundary.
- Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble 10..15 decodes to 79 ('E').
- Load:
  - bcd_load=1 captures unpacked_bcd into the pending register and sets pending=1.
  - A later load before the boundary overwrites the pending register (last write wins).
- Frame-boundary update:
  - If pending=1, display takes the pending register and pending clears.
  - If bcd_load=1 in the same cycle as a frame-boundary tick, unpacked_bcd bypasses straight to display, pending clears, and DIG0 shows the new digit0 on that edge.
- frame_done: high for exactly the one cycle following each frame-boundary edge, coincident with an=4'b1110 first appearing. It is zero otherwise, including while in OFF.
- Latency:
  - bcd_load to visible: at most 4*SCAN_DIV+1 cycles after the strobe.
  - Reset release to first digit: SCAN_DIV cycles.
- Reset mid-frame: all state returns to reset values immediately; pending data is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - While in DIGk with k in {3,2,1}, seg=7'h00 if display digit k and all higher digits are 0. an still selects the digit.
  - Digit0 is never blanked.
  - Example: 16'h0025 shows blank, blank, 2, 5.
- Undefined: every digit is decoded normally (16'h0025 shows 0,0,2,5). No extra logic is synthesised.

Test Plan:
- Reset hold 3 cycles, then release, SCAN_DIV=4 -> an=1111, seg=00, frame_done=0 for 4 cycles. Then an=1110, seg=3F, frame_done=1 for one cycle.
- bcd_load with 16'h0255 during OFF -> at the first boundary, display steps through digit0..3 showing 6D, 6D, 5B, 3F. an rotates 1110, 1101, 1011, 0111, each held 4 cycles; pending falls at the boundary.
- Loads 16'h0128 then 16'h0099 within one frame -> the next frame shows 6F, 6F, 3F, 3F (last write wins). The current frame is unchanged mid-frame.
- bcd_load 16'h0007 on the same cycle as the DIG3->DIG0 tick -> the DIG0 slot on that edge shows 07; pending stays 0.
- unpacked_bcd 16'hA0F3 -> segments per digit0..3: 4F, 79, 3F, 79.
- rst_n low for 1 cycle while in DIG2 with pending=1 -> an=1111, seg=00, pending=0 asynchronously. After release, the first frame shows all zeros (3F on every digit; with LEADING_ZERO_BLANK_EN, digits 3..1 are blank and digit0 is 3F).
